// File: rtl/layer_stream_host.sv
`default_nettype none
// ============================================================================
// Module  : layer_stream_host
// Brief   : Host endpoint that streams a batch of input vectors into a layer
//           and collects the layer's result words for readback.
// Revision: 1.0
// ============================================================================
module layer_stream_host #(
    parameter int T    = 12,
    parameter int N    = 8,
    parameter int M    = 8,
    parameter int NVEC = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          cfg_wr_en,
    input  logic [$clog2(NVEC*N)-1:0]     cfg_wr_addr,
    input  logic [T-1:0]                  cfg_wr_data,
    input  logic                          start,
    input  logic [$clog2(NVEC+1)-1:0]     num_vec,
    output logic                          busy,
    output logic                          done,
    output logic                          tx_valid,
    input  logic                          tx_ready,
    output logic [T-1:0]                  tx_data,
    input  logic                          rx_valid,
    output logic                          rx_ready,
    input  logic [T-1:0]                  rx_data,
    input  logic [$clog2(NVEC*M)-1:0]     res_rd_addr,
    output logic [T-1:0]                  res_rd_data,
    output logic [$clog2(NVEC*M+1)-1:0]   rx_count
);

    localparam int c_iaw = $clog2(NVEC*N);
    localparam int c_raw = $clog2(NVEC*M);
    localparam int c_tcw = $clog2(NVEC*N+1);
    localparam int c_rcw = $clog2(NVEC*M+1);
    localparam int c_nvw = $clog2(NVEC+1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [T-1:0]       r_ibuf [NVEC*N];
    logic [T-1:0]       r_rbuf [NVEC*M];

    logic               r_tx_valid;
    logic [T-1:0]       r_tx_data;
    logic [c_tcw-1:0]   r_tx_cnt;
    logic [c_tcw-1:0]   r_tx_total;
    logic [c_rcw-1:0]   r_rx_cnt;
    logic [c_rcw-1:0]   r_rx_total;
    logic [T-1:0]       r_res_rd_data;

    logic [c_nvw-1:0]   w_nv;
    logic [c_tcw-1:0]   w_tx_nxt;
    logic               w_tx_fire;
    logic               w_rx_fire;
    logic               w_rx_ready;
    logic               w_busy;
    logic               w_done;
    logic               w_start_ok;

    assign w_nv       = (num_vec > c_nvw'(NVEC)) ? c_nvw'(NVEC) : num_vec;
    assign w_start_ok = (r_state == S_IDLE) && start;
    assign w_tx_nxt   = r_tx_cnt + c_tcw'(1);
    assign w_tx_fire  = r_tx_valid && tx_ready;
    assign w_rx_fire  = rx_valid && w_rx_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_busy      = 1'b0;
        w_done      = 1'b0;
        w_rx_ready  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = (w_nv == '0) ? S_FIN : S_RUN;
                end
            end
            S_RUN: begin
                w_busy     = 1'b1;
                w_rx_ready = (r_rx_cnt < r_rx_total);
                if ((r_tx_cnt == r_tx_total) && (r_rx_cnt == r_rx_total)) begin
                    w_state_nxt = S_FIN;
                end
            end
            S_FIN: begin
                w_busy      = 1'b1;
                w_done      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // tx_data is reloaded only on a handshake, so it holds steady across stalls
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tx_valid <= 1'b0;
            r_tx_data  <= '0;
            r_tx_cnt   <= '0;
            r_tx_total <= '0;
            r_rx_cnt   <= '0;
            r_rx_total <= '0;
        end else if (w_start_ok) begin
            r_tx_total <= c_tcw'(w_nv) * c_tcw'(N);
            r_rx_total <= c_rcw'(w_nv) * c_rcw'(M);
            r_tx_cnt   <= '0;
            r_rx_cnt   <= '0;
            r_tx_valid <= (w_nv != '0);
            r_tx_data  <= r_ibuf[0];
        end else if (r_state == S_RUN) begin
            if (w_tx_fire) begin
                r_tx_cnt <= w_tx_nxt;
                if (w_tx_nxt < r_tx_total) begin
                    r_tx_data <= r_ibuf[w_tx_nxt[c_iaw-1:0]];
                end else begin
                    r_tx_valid <= 1'b0;
                end
            end
            if (w_rx_fire) begin
                r_rx_cnt <= r_rx_cnt + c_rcw'(1);
            end
        end
    end

    // Buffer storage is never cleared by reset
    always_ff @(posedge clk) begin
        if ((r_state == S_IDLE) && cfg_wr_en) begin
            r_ibuf[cfg_wr_addr] <= cfg_wr_data;
        end
        if (w_rx_fire) begin
            r_rbuf[r_rx_cnt[c_raw-1:0]] <= rx_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_res_rd_data <= '0;
        end else begin
            r_res_rd_data <= r_rbuf[res_rd_addr];
        end
    end

    assign busy        = w_busy;
    assign done        = w_done;
    assign tx_valid    = r_tx_valid;
    assign tx_data     = r_tx_data;
    assign rx_ready    = w_rx_ready;
    assign rx_count    = r_rx_cnt;
    assign res_rd_data = r_res_rd_data;

endmodule
`default_nettype wire
